// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared definitions for the fabric-to-PPC snapshot register: register map,
// STATUS/CTRL field positions and the OPB slave handshake states.
package opb_snap_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int ST_NEW_BIT     = 0;
  localparam int ST_OVR_BIT     = 1;
  localparam int ST_CNT_LSB     = 16;
  localparam int ST_CNT_WIDTH   = 16;

  localparam int CT_FREEZE_BIT  = 0;
  localparam int CT_OVR_CLR_BIT = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Generic single-beat OPB slave handshake: decodes an address window, issues a
// one-cycle registered ack and presents the latched word offset with rd/wr strobes.
module opb_slave_ack_fsm
  import opb_snap_pkg::*;
#(
  parameter logic [31:0] BASEADDR = 32'h01008100,
  parameter logic [31:0] HIGHADDR = 32'h010081FF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic        rnw_i,
  input  logic [31:0] addr_i,
  output logic        start_o,
  output logic        ack_o,
  output logic        rd_stb_o,
  output logic        wr_stb_o,
  output logic [1:0]  offset_o
);

  bus_state_e  state_q;
  logic        ack_q;
  logic        rnw_q;
  logic [1:0]  offset_q;
  logic        hit;

  assign hit     = sel_i && (addr_i >= BASEADDR) && (addr_i <= HIGHADDR);
  assign start_o = (state_q == S_IDLE) && hit;

  // Select is not looked at in ACK, so a master holding select across the ack
  // cannot trigger a second transfer in the very next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      rnw_q    <= 1'b0;
      offset_q <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            state_q  <= S_ACK;
            ack_q    <= 1'b1;
            rnw_q    <= rnw_i;
            offset_q <= addr_i[3:2];
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o    = ack_q;
  assign rd_stb_o = ack_q && rnw_q;
  assign wr_stb_o = ack_q && !rnw_q;
  assign offset_o = offset_q;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Captures a user-logic word on a strobe and exposes it, with NEW/OVERRUN flags
// and a capture counter, as a read-mostly OPB slave on the shared OPB clock.
module opb_register_simulink2ppc_snap
  import opb_snap_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01008100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010081FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid
);

  // Bus vectors are MSB-first at index 0, so plain assignment maps bus bit i to reg bit 31-i.
  logic [31:0] addr;
  logic [31:0] wdata;
  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;

  logic       start;
  logic       ack;
  logic       rd_stb;
  logic       wr_stb;
  logic [1:0] offset;

  opb_slave_ack_fsm #(
    .BASEADDR (C_BASEADDR),
    .HIGHADDR (C_HIGHADDR)
  ) u_ack_fsm (
    .clk_i    (OPB_Clk),
    .rst_i    (OPB_Rst),
    .sel_i    (OPB_select),
    .rnw_i    (OPB_RNW),
    .addr_i   (addr),
    .start_o  (start),
    .ack_o    (ack),
    .rd_stb_o (rd_stb),
    .wr_stb_o (wr_stb),
    .offset_o (offset)
  );

  logic [31:0]             data_q,    data_d;
  logic                    new_q,     new_d;
  logic                    ovr_q,     ovr_d;
  logic                    frz_q,     frz_d;
  logic [ST_CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic [31:0]             rdata_q,   rdata_d;
  logic                    wr_frz_q;
  logic                    wr_clr_q;
  logic                    wr_be_q;

  logic capture;
  logic data_rd;
  logic ctrl_wr;

  assign capture = user_data_valid && !frz_q;
  assign data_rd = rd_stb && (offset == OFF_DATA);
  assign ctrl_wr = wr_stb && (offset == OFF_CTRL) && wr_be_q;

  // Capture is evaluated last so a same-cycle strobe re-arms NEW and wins over an OVERRUN clear.
  always_comb begin
    data_d = data_q;
    new_d  = new_q;
    ovr_d  = ovr_q;
    frz_d  = frz_q;
    cnt_d  = cnt_q;
    if (data_rd) begin
      new_d = 1'b0;
    end
    if (ctrl_wr) begin
      frz_d = wr_frz_q;
      if (wr_clr_q) begin
        ovr_d = 1'b0;
      end
    end
    if (capture) begin
      data_d = user_data_in;
      new_d  = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (new_q && !data_rd) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (start && OPB_RNW) begin
      case (addr[3:2])
        OFF_DATA: rdata_d = data_q;
        OFF_STATUS: begin
          rdata_d[ST_CNT_LSB +: ST_CNT_WIDTH] = cnt_q;
          rdata_d[ST_OVR_BIT]                 = ovr_q;
          rdata_d[ST_NEW_BIT]                 = new_q;
        end
        OFF_CTRL: rdata_d[CT_FREEZE_BIT] = frz_q;
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      data_q   <= '0;
      new_q    <= 1'b0;
      ovr_q    <= 1'b0;
      frz_q    <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      wr_frz_q <= 1'b0;
      wr_clr_q <= 1'b0;
      wr_be_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      new_q   <= new_d;
      ovr_q   <= ovr_d;
      frz_q   <= frz_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (start) begin
        wr_frz_q <= wdata[CT_FREEZE_BIT];
        wr_clr_q <= wdata[CT_OVR_CLR_BIT];
        wr_be_q  <= OPB_BE[3];
      end
    end
  end

  assign Sl_DBus    = rdata_q;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:2], C_FAMILY};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Randomised OPB master plus scoreboard for the snapshot register; expected
// read data comes from a behavioural model of the register map.
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] BASE = 32'h01008100;
  localparam logic [31:0] HIGH = 32'h010081FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        ack, err, retry, tout;
  logic [31:0] udata = '0;
  logic        uvalid = 1'b0;

  int total = 0;
  int bad   = 0;
  int ntxn  = 0;

  logic [31:0] exp_q[$];

  // Behavioural model of the visible register state.
  bit [31:0]   m_data;
  bit          m_new, m_ovr, m_frz;
  int unsigned m_cnt;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seq),
    .Sl_DBus         (sl_dbus),
    .Sl_xferAck      (ack),
    .Sl_errAck       (err),
    .Sl_retry        (retry),
    .Sl_toutSup      (tout),
    .user_data_in    (udata),
    .user_data_valid (uvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", name, act, want);
    end
  endtask

  function automatic bit [31:0] m_read(input bit [1:0] off);
    case (off)
      2'd0:    return m_data;
      2'd1:    return ((m_cnt % 65536) << 16) | (32'(m_ovr) << 1) | 32'(m_new);
      2'd2:    return 32'(m_frz);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_cap(input bit [31:0] d, input bit old_new, input bit old_frz,
                                input bit cleared);
    if (old_frz) return;
    if (old_new && !cleared) m_ovr = 1'b1;
    m_data = d;
    m_new  = 1'b1;
    m_cnt  = (m_cnt + 1) % 65536;
  endfunction

  function automatic void m_reset();
    m_data = 0; m_new = 0; m_ovr = 0; m_frz = 0; m_cnt = 0;
  endfunction

  // Monitor: pops the scoreboard on every ack, and checks the bus is quiet otherwise.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
    end else begin
      if (ack) begin
        chk("ack_one_cycle", 32'(prev_ack), 32'h0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got=%08h want=no_ack", sl_dbus);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          ntxn++;
          $display("txn %0d: Sl_DBus=%08h expected=%08h", ntxn, sl_dbus, e);
          chk("rdata", sl_dbus, e);
        end
      end else begin
        chk("dbus_idle", sl_dbus, 32'h0);
      end
      prev_ack = ack;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; sel = 1'b0; uvalid = 1'b0;
    @(posedge clk); #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_dbus", sl_dbus, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic strobe(input logic [31:0] d);
    @(posedge clk); #1;
    uvalid = 1'b1; udata = d;
    m_cap(d, m_new, m_frz, 1'b0);
    @(posedge clk); #1;
    uvalid = 1'b0;
  endtask

  // One OPB transfer; optional capture strobe placed in the ack cycle.
  task automatic bus(input logic [31:0] a, input bit rd, input logic [31:0] wd,
                     input logic [0:3] b, input bit stb, input logic [31:0] sv);
    bit       hit;
    bit [1:0] off;
    bit       old_new, old_frz, clr;
    hit = (a >= BASE) && (a <= HIGH);
    off = a[3:2];
    @(posedge clk); #1;
    sel = 1'b1; abus = a; rnw = rd; dbus = wd; be = b;
    if (hit) begin
      exp_q.push_back(rd ? m_read(off) : 32'h0);
      @(posedge clk); #1;
      chk("ack_latency", 32'(ack), 32'h1);
      sel = 1'b0;
      if (stb) begin uvalid = 1'b1; udata = sv; end
      old_new = m_new; old_frz = m_frz;
      clr = rd && (off == 2'd0);
      if (clr) m_new = 1'b0;
      if (!rd && off == 2'd2 && b[3]) begin
        m_frz = wd[0];
        if (wd[1]) m_ovr = 1'b0;
      end
      if (stb) m_cap(sv, old_new, old_frz, clr);
      @(posedge clk); #1;
      uvalid = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        chk("miss_no_ack", 32'(ack), 32'h0);
      end
      sel = 1'b0;
    end
  endtask

  task automatic rd_reg(input bit [1:0] off);
    bus(BASE + {28'h0, off, 2'b00}, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0);
  endtask

  task automatic wr_reg(input bit [1:0] off, input logic [31:0] wd, input logic [0:3] b);
    bus(BASE + {28'h0, off, 2'b00}, 1'b0, wd, b, 1'b0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tieoffs", {29'h0, err, retry, tout}, 32'h0);
    rst = 1'b0;

    // Reset state and basic capture/read
    rd_reg(2'd1);
    strobe(32'hDEADBEEF);
    rd_reg(2'd0);
    rd_reg(2'd1);

    // Overrun, byte-enable gating and clear
    do_reset();
    strobe(32'h1);
    strobe(32'h2);
    rd_reg(2'd1);
    wr_reg(2'd2, 32'h2, 4'b1110);
    rd_reg(2'd1);
    wr_reg(2'd2, 32'h2, 4'b1111);
    rd_reg(2'd1);

    // Freeze drops strobes
    wr_reg(2'd2, 32'h1, 4'b1111);
    strobe(32'h55);
    rd_reg(2'd0);
    rd_reg(2'd1);
    rd_reg(2'd2);
    wr_reg(2'd2, 32'h0, 4'b1111);

    // Capture during DATA read ack, then overrun-set racing an overrun clear
    strobe(32'hA5A5_0001);
    bus(BASE, 1'b1, 32'h0, 4'b1111, 1'b1, 32'hA5A5_0002);
    rd_reg(2'd1);
    bus(BASE + 32'h8, 1'b0, 32'h2, 4'b1111, 1'b1, 32'hA5A5_0003);
    rd_reg(2'd1);
    rd_reg(2'd0);

    // Writes to read-only offsets and offset 0xC
    wr_reg(2'd0, 32'hFFFF_FFFF, 4'b1111);
    wr_reg(2'd1, 32'hFFFF_FFFF, 4'b1111);
    wr_reg(2'd3, 32'hFFFF_FFFF, 4'b1111);
    rd_reg(2'd3);
    rd_reg(2'd0);
    rd_reg(2'd1);

    // Counter wrap
    do_reset();
    @(posedge clk); #1;
    uvalid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      udata = 32'(i);
      m_cap(32'(i), m_new, m_frz, 1'b0);
      @(posedge clk); #1;
    end
    uvalid = 1'b0;
    rd_reg(2'd1);
    strobe(32'h1234_5678);
    rd_reg(2'd1);
    rd_reg(2'd0);

    // Window boundaries
    bus(BASE - 32'h1, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0);
    bus(HIGH + 32'h1, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0);
    bus(HIGH, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0);
    bus(BASE + 32'h5, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0);

    // Reset arriving while the slave is in its ack cycle
    strobe(32'hCAFE_F00D);
    @(posedge clk); #1;
    sel = 1'b1; abus = BASE + 32'h4; rnw = 1'b1; be = 4'b1111;
    @(posedge clk); #1;
    chk("ack_before_rst", 32'(ack), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_kills_ack", 32'(ack), 32'h0);
    chk("rst_kills_dbus", sl_dbus, 32'h0);
    sel = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    rd_reg(2'd0);
    rd_reg(2'd1);
    rd_reg(2'd2);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      int unsigned pick;
      pick = $urandom_range(0, 9);
      if (pick <= 2) begin
        for (int k = 0; k <= int'($urandom_range(0, 2)); k++) strobe($urandom);
      end else if (pick <= 8) begin
        logic [31:0] a;
        logic [0:3]  b;
        a = BASE + {$urandom_range(0, 63), 2'b00} + $urandom_range(0, 3);
        b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
        bus(a, 1'($urandom), $urandom, b, ($urandom_range(0, 3) == 0), $urandom);
      end else begin
        logic [31:0] a;
        a = ($urandom_range(0, 1) == 0) ? (BASE - 32'h1 - ($urandom % 4096))
                                        : (HIGH + 32'h1 + ($urandom % 4096));
        bus(a, 1'($urandom), $urandom, 4'b1111, 1'b0, 32'h0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
